// File: rtl/canvas_plotter.sv
// Owns the 28x28 1-bit drawing canvas and turns cell paint/clear requests into
// per-pixel plot strobes for a 160x120 3-bit-colour VGA adapter. A registered
// read port lets the classifier fetch the drawn image.
module canvas_plotter #(
  parameter int unsigned GRID_SIZE     = 28,
  parameter int unsigned PIXEL_SIZE    = 4,
  parameter int unsigned GRID_OFFSET_X = 16,
  parameter int unsigned GRID_OFFSET_Y = 12,
  parameter logic [2:0]  FG_COLOUR     = 3'b111,
  parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       paint_valid,
  output logic       paint_ready,
  input  logic [4:0] paint_x,
  input  logic [4:0] paint_y,
  input  logic       paint_val,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  input  logic [9:0] rd_addr,
  output logic       rd_data
);

  localparam int unsigned Cells = GRID_SIZE * GRID_SIZE;
  localparam int unsigned SubW  = $clog2(PIXEL_SIZE);
  localparam int unsigned SubN  = 2 * SubW;

  typedef enum logic [1:0] {StIdle, StPlot, StClear} state_e;

  state_e            r_state;
  logic [Cells-1:0]  r_canvas;
  logic [4:0]        r_x;
  logic [4:0]        r_y;
  logic              r_val;
  logic [SubN-1:0]   r_sub;   // {sy, sx} of the pixel currently on the outputs
  logic [9:0]        r_cell;  // clear walk position
  logic              r_ready;
  logic              r_busy;
  logic              r_plot;
  logic [7:0]        r_vx;
  logic [6:0]        r_vy;
  logic [2:0]        r_col;
  logic              r_rd;

  logic              w_in_range;
  logic [9:0]        w_paint_addr;
  logic [SubN-1:0]   w_sub_next;
  logic              w_last_sub;
  logic              w_wrap;
  logic [4:0]        w_nx;
  logic [4:0]        w_ny;

  assign w_in_range   = (32'(paint_x) < GRID_SIZE) && (32'(paint_y) < GRID_SIZE);
  assign w_paint_addr = 10'(32'(paint_y) * GRID_SIZE + 32'(paint_x));
  assign w_sub_next   = r_sub + {{(SubN-1){1'b0}}, 1'b1};
  assign w_last_sub   = &r_sub;
  assign w_wrap       = (r_x == 5'(GRID_SIZE - 1));
  assign w_nx         = w_wrap ? 5'd0 : r_x + 5'd1;
  assign w_ny         = w_wrap ? r_y + 5'd1 : r_y;

  function automatic logic [7:0] pix_x(input logic [4:0] cx, input logic [SubN-1:0] sub);
    return 8'(GRID_OFFSET_X + 32'(cx) * PIXEL_SIZE + 32'(sub[SubW-1:0]));
  endfunction

  // Computed at 8 bits; only narrowed once it is known to fit the 7-bit bus.
  function automatic logic [6:0] pix_y(input logic [4:0] cy, input logic [SubN-1:0] sub);
    logic [7:0] y8;
    y8 = 8'(GRID_OFFSET_Y + 32'(cy) * PIXEL_SIZE + 32'(sub[SubN-1:SubW]));
    return (y8 < 8'd128) ? y8[6:0] : 7'd0;
  endfunction

  assign paint_ready = r_ready;
  assign busy        = r_busy;
  assign vga_plot    = r_plot;
  assign vga_x       = r_vx;
  assign vga_y       = r_vy;
  assign vga_colour  = r_col;
  assign rd_data     = r_rd;

  // Control FSM: canvas writes, request handshake and registered plot outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_canvas <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_val    <= 1'b0;
      r_sub    <= '0;
      r_cell   <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_plot   <= 1'b0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_col    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Clear wins; a simultaneous paint stays pending on the held valid.
          if (clear_req) begin
            r_state <= StClear;
            r_x     <= '0;
            r_y     <= '0;
            r_cell  <= '0;
            r_sub   <= '0;
            r_plot  <= 1'b1;
            r_vx    <= pix_x(5'd0, '0);
            r_vy    <= pix_y(5'd0, '0);
            r_col   <= BG_COLOUR;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else if (paint_valid) begin
            r_x   <= paint_x;
            r_y   <= paint_y;
            r_val <= paint_val;
            // Off-grid requests are consumed without effect.
            if (w_in_range) begin
              r_canvas[w_paint_addr] <= paint_val;
              r_state <= StPlot;
              r_sub   <= '0;
              r_plot  <= 1'b1;
              r_vx    <= pix_x(paint_x, '0);
              r_vy    <= pix_y(paint_y, '0);
              r_col   <= paint_val ? FG_COLOUR : BG_COLOUR;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        StPlot, StClear: begin
          if (r_state == StClear) begin
            r_canvas[r_cell] <= 1'b0;
          end
          if (!w_last_sub) begin
            r_sub <= w_sub_next;
            r_vx  <= pix_x(r_x, w_sub_next);
            r_vy  <= pix_y(r_y, w_sub_next);
          end else if (r_state == StClear && r_cell != 10'(Cells - 1)) begin
            r_cell <= r_cell + 10'd1;
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_sub  <= '0;
            r_vx   <= pix_x(w_nx, '0);
            r_vy   <= pix_y(w_ny, '0);
          end else begin
            r_state <= StIdle;
            r_plot  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Registered read port; sees the canvas as it was before this edge's write.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_rd <= 1'b0;
    end else begin
      r_rd <= (rd_addr < 10'(Cells)) ? r_canvas[rd_addr] : 1'b0;
    end
  end

endmodule

// File: tb/tb_canvas_plotter.sv
// Self-checking bench for canvas_plotter: a pixel-queue reference model plus
// directed scenarios with literal expectations and a randomized paint phase.
module tb_canvas_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       paint_valid = 1'b0;
  logic       paint_ready;
  logic [4:0] paint_x = '0;
  logic [4:0] paint_y = '0;
  logic       paint_val = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [9:0] rd_addr = '0;
  logic       rd_data;

  canvas_plotter dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .paint_valid(paint_valid),
    .paint_ready(paint_ready),
    .paint_x    (paint_x),
    .paint_y    (paint_y),
    .paint_val  (paint_val),
    .clear_req  (clear_req),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted request expands into its list of pixels.
  typedef struct {int x; int y; int c;} pix_t;
  pix_t q[$];
  bit   m_canvas[784];
  bit   exp_plot = 1'b0;
  int   exp_x = 0, exp_y = 0, exp_c = 0;
  bit   exp_rd = 1'b0;
  bit   m_clearing = 1'b0;
  int   rd_skip = 0;

  task automatic push_cell(input int cx, input int cy, input int c);
    pix_t p;
    for (int sy = 0; sy < 4; sy++)
      for (int sx = 0; sx < 4; sx++) begin
        p.x = 16 + cx * 4 + sx;
        p.y = 12 + cy * 4 + sy;
        p.c = c;
        q.push_back(p);
      end
  endtask

  always @(posedge clk or negedge resetn) begin
    pix_t p;
    if (!resetn) begin
      q.delete();
      exp_plot = 1'b0;
      exp_rd = 1'b0;
      m_clearing = 1'b0;
      rd_skip = 0;
      foreach (m_canvas[i]) m_canvas[i] = 1'b0;
    end else begin
      exp_rd = (rd_addr < 784) ? m_canvas[rd_addr] : 1'b0;
      if (q.size() == 0 && exp_plot) begin
        exp_plot = 1'b0;   // one idle cycle after the final pixel of a request
        m_clearing = 1'b0;
      end else if (q.size() == 0) begin
        if (clear_req) begin
          foreach (m_canvas[i]) m_canvas[i] = 1'b0;
          for (int c = 0; c < 784; c++) push_cell(c % 28, c / 28, 0);
          m_clearing = 1'b1;
        end else if (paint_valid && paint_x < 28 && paint_y < 28) begin
          m_canvas[paint_y * 28 + paint_x] = paint_val;
          push_cell(paint_x, paint_y, paint_val ? 7 : 0);
        end
      end
      if (q.size() > 0) begin
        p = q.pop_front();
        exp_plot = 1'b1;
        exp_x = p.x;
        exp_y = p.y;
        exp_c = p.c;
      end
      // Per-cell clear timing is not pinned down, so reads are not compared then.
      rd_skip = m_clearing ? 2 : (rd_skip > 0 ? rd_skip - 1 : 0);
    end
  end

  int plot_cnt = 0;
  int last_x = 0, last_y = 0;

  // Single compare process against the model, every cycle.
  always @(negedge clk) begin
    if (vga_plot) begin
      plot_cnt++;
      last_x = vga_x;
      last_y = vga_y;
    end
    chk("vga_plot", vga_plot, exp_plot);
    chk("paint_ready", paint_ready, !exp_plot);
    chk("busy", busy, exp_plot);
    if (exp_plot) begin
      chk("vga_x", vga_x, exp_x);
      chk("vga_y", vga_y, exp_y);
      chk("vga_colour", vga_colour, exp_c);
    end
    if (rd_skip == 0) chk("rd_data", rd_data, exp_rd);
  end

  bit rnd_rd = 1'b0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_rd) rd_addr = 10'($urandom_range(0, 1023));
  endtask

  task automatic do_paint(input int x, input int y, input bit v);
    bit acc;
    int waited;
    paint_x = 5'(x);
    paint_y = 5'(y);
    paint_val = v;
    paint_valid = 1'b1;
    waited = 0;
    forever begin
      acc = !exp_plot && !clear_req;
      tick();
      if (acc) break;
      waited++;
      if (waited > 20000) begin
        chk("paint_accept_timeout", 0, 1);
        break;
      end
    end
    paint_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i <= 20000; i++) begin
      if (!exp_plot) return;
      tick();
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic read_cell(input int addr, input int exp, input string name);
    rd_addr = 10'(addr);
    @(posedge clk);
    @(negedge clk);
    chk(name, rd_data, exp);
    #2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    #1 resetn = 1'b0;
    #1;
    chk("reset_ready", paint_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_plot", vga_plot, 0);
    chk("reset_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("reset_rd", rd_data, 0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    tick();

    // 1) centre cell
    do_paint(14, 14, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t1_ready_low", paint_ready, 0);
      chk("t1_x", vga_x, 72 + i % 4);
      chk("t1_y", vga_y, 68 + i / 4);
      chk("t1_colour", vga_colour, 7);
    end
    tick();
    @(negedge clk);
    chk("t1_ready_back", paint_ready, 1);
    #2;
    read_cell(406, 1, "t1_rd406");

    // 2) back-to-back paints, second held off for 16 plots
    do_paint(0, 0, 1);
    p0 = plot_cnt;
    do_paint(27, 27, 1);
    chk("t2_plots_before_accept", plot_cnt - p0, 16);
    wait_idle();
    tick();
    chk("t2_last_x", last_x, 127);
    chk("t2_last_y", last_y, 123);

    // 3) off-grid column is swallowed
    p0 = plot_cnt;
    do_paint(28, 5, 1);
    repeat (3) tick();
    chk("t3_no_plot", plot_cnt - p0, 0);
    chk("t3_ready", paint_ready, 1);
    read_cell(168, 0, "t3_no_alias");

    // 4) clear beats a simultaneous paint
    paint_x = 5'd5;
    paint_y = 5'd5;
    paint_val = 1'b1;
    paint_valid = 1'b1;
    clear_req = 1'b1;
    p0 = plot_cnt;
    tick();
    clear_req = 1'b0;
    do_paint(5, 5, 1);
    chk("t4_clear_plots", plot_cnt - p0, 12544);
    wait_idle();
    tick();
    for (int i = 0; i < 784; i++) read_cell(i, (i == 145) ? 1 : 0, "t4_canvas");

    // 5) set then erase
    do_paint(3, 3, 1);
    wait_idle();
    tick();
    do_paint(3, 3, 0);
    @(negedge clk);
    chk("t5_erase_colour", vga_colour, 0);
    chk("t5_erase_plot", vga_plot, 1);
    wait_idle();
    tick();
    read_cell(87, 0, "t5_rd87");

    // 6) reset in the middle of a clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5000) tick();
    chk("t6_mid_clear_plot", vga_plot, 1);
    resetn = 1'b0;
    #1;
    chk("t6_abort_plot", vga_plot, 0);
    chk("t6_abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (2) tick();
    chk("t6_ready_after", paint_ready, 1);
    chk("t6_plot_after", vga_plot, 0);

    // Randomized paints, erases, off-grid requests and reads.
    rnd_rd = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_paint($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (4) tick();
    rnd_rd = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
